dpram_stream_reader: RTL and testbench
======================================

# dpram_stream_reader

Read-side controller for the single-clock simple dual-port RAM in the bitonic mesh datapath. On a start command it sweeps a contiguous address range on the RAM read port, absorbs the RAM's one-cycle registered read latency, and presents the words as a valid/ready stream with a last marker. It sits between the RAM's read port (address out, registered data in) and the downstream sort/merge stage that consumes buffered columns.

## Interface
- AWIDTH, 5, RAM address width; also read-address output width
- DWIDTH, 32, RAM word width
- clk  input  1  single clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a sweep; sampled only in IDLE
- base  input  AWIDTH  first address of sweep, captured on start
- len  input  AWIDTH+1  word count, captured on start; 0..2^AWIDTH
- rd_addr  output  AWIDTH  RAM read address (to RAM addr_a)
- rd_data  input  DWIDTH  RAM registered read data (from RAM q_a)
- m_valid  output  1  stream word valid
- m_ready  input  1  downstream accepts word
- m_data  output  DWIDTH  stream word
- m_last  output  1  high with final word of the sweep
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse at end of sweep

## Operation
- States: IDLE, RUN, DRAIN. IDLE -> RUN on start with len != 0; IDLE -> IDLE with done pulse next cycle on start with len == 0 (no beats emitted).
- RUN: issue one read per cycle when buf_count + inflight < 4. Issue = rd_addr currently driven is the next address; address register advances; one pipeline valid bit enters the 2-stage in-flight tracker (issue cycle N, rd_data valid in N+1, written into buffer at end of N+1).
- Address arithmetic: rd_addr = base + i, modulo 2^AWIDTH (wraps past top of RAM). Remaining-issue counter AWIDTH+1 bits, decrements per issue.
- RUN -> DRAIN when final read issued. DRAIN -> IDLE when final word is accepted (m_valid & m_ready & m_last); done pulses the cycle after, busy drops with it.
- Output buffer: 4-entry FIFO; simultaneous push and pop in one cycle allowed, count unchanged. Overflow impossible by issue rule; pop only on m_valid & m_ready.
- m_last tagged at issue time on the final read and carried through buffer with data.
- m_data/m_valid/m_last held stable while m_valid & !m_ready.
- start while busy: ignored, no effect on captured base/len.
- rst mid-sweep: all state to reset values immediately; buffered and in-flight words discarded; no done pulse.
- Reset values: rd_addr 0, m_valid 0, m_data 0, m_last 0, busy 0, done 0; state IDLE.

## Timing
- start high in cycle 0 -> busy high cycle 1, first address on rd_addr cycle 1, first m_valid cycle 3.
- With m_ready held high: one word per cycle sustained; len words occupy cycles 3..len+2; done in cycle len+3.
- Backpressure: issue stalls within 1 cycle of buffer+inflight reaching 4; no word lost or duplicated.
- RAM write port concurrent with sweep: read-during-write to the same address returns old data (RAM behaviour); not hidden by this block.

## Configuration
- DPRAM_RD_LOOP_EN defined: extra input port loop (1 bit). If loop is high when the final read issues, the block reloads base/len and continues in RUN without passing IDLE; m_last still marks each pass's final word; done pulses per pass only when loop is low at the final issue.
- Undefined: no loop port; each start yields exactly one sweep.

## Structure
- Package dpram_rd_pkg: state enum (IDLE, RUN, DRAIN), BUF_DEPTH = 4, INFLIGHT_MAX = 2.
- Sub-module dpram_rd_skid_fifo: 4-entry DWIDTH+1-wide FIFO with count output, simultaneous push/pop.

## Test plan
- base=0, len=8, m_ready=1, RAM preloaded ram[i]=i -> m_data 0..7 in cycles 3..10, m_last at 7, done cycle 11.
- base=30, len=4 (AWIDTH=5) -> rd_addr 30,31,0,1; data in that order, no gap.
- len=8, m_ready toggled 1,0,0,1 repeating -> all 8 words in order, stable data while stalled, inflight+count never > 4.
- len=0 start -> done pulse cycle 1, m_valid never high; start during busy -> ignored, sweep unchanged.
- rst asserted mid-sweep after 3 words -> all outputs 0 same cycle; next start base=4,len=2 -> words ram[4],ram[5] only.
- DPRAM_RD_LOOP_EN, loop=1, len=3 -> repeating 3-word passes with m_last each pass; drop loop -> done after current pass.

Source files
------------

// File: rtl/dpram_rd_pkg.sv
// Shared types and constants for the dual-port RAM stream reader.
package dpram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int BUF_DEPTH    = 4;
    localparam int INFLIGHT_MAX = 2;

    // A new read may be issued only while buffered plus in-flight words leave room.
    function automatic logic can_issue(input logic [2:0] count, input logic inflight);
        return (({1'b0, count} + {3'b000, inflight}) < 4'(BUF_DEPTH));
    endfunction

endpackage

// File: rtl/dpram_rd_skid_fifo.sv
// Four-entry output buffer between the RAM read pipeline and the stream port.
// Push and pop may occur in the same cycle; the head word is visible directly.
module dpram_rd_skid_fifo
    import dpram_rd_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [2:0]       o_count
);

    logic [WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [1:0]       r_wr_ptr;
    logic [1:0]       r_rd_ptr;
    logic [2:0]       r_count;

    // Storage, pointers and occupancy; storage clears so the head reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/dpram_stream_reader.sv
// Read-side controller for the simple dual-port RAM: sweeps base..base+len-1
// (modulo RAM size), hides the one-cycle registered read latency and emits a
// valid/ready stream with a last marker.
// Optional feature macro: DPRAM_RD_LOOP_EN adds a 'loop' input that restarts the
// sweep from the captured base/len after each pass without returning to IDLE.
module dpram_stream_reader
    import dpram_rd_pkg::*;
#(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] base,
    input  logic [AWIDTH:0]   len,
`ifdef DPRAM_RD_LOOP_EN
    input  logic              loop,
`endif
    output logic [AWIDTH-1:0] rd_addr,
    input  logic [DWIDTH-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    state_t            r_state;
    logic [AWIDTH-1:0] r_addr;
    logic [AWIDTH:0]   r_remain;
    logic [AWIDTH-1:0] r_base;
    logic [AWIDTH:0]   r_len;
    logic              r_p1_valid;
    logic              r_p1_last;
    logic              r_busy;
    logic              r_done;

    logic [2:0]        w_count;
    logic [DWIDTH:0]   w_head;
    logic [$clog2(INFLIGHT_MAX)-1:0] w_inflight;
    logic              w_issue;
    logic              w_final_issue;
    logic              w_pop;
    logic              w_pop_final;
    logic              w_loop;

`ifdef DPRAM_RD_LOOP_EN
    assign w_loop = loop;
`else
    assign w_loop = 1'b0;
`endif

    assign w_inflight = r_p1_valid;

    // Issue, pop and end-of-sweep decisions for the current cycle.
    always_comb begin
        w_issue       = (r_state == RUN) && can_issue(w_count, w_inflight);
        w_final_issue = w_issue && (r_remain == (AWIDTH+1)'(1));
        w_pop         = m_valid && m_ready;
        // The sweep ends only when its last word leaves and nothing else is outstanding;
        // this also skips earlier-pass last words still queued in loop mode.
        w_pop_final   = w_pop && w_head[DWIDTH] && (w_count == 3'd1) && !r_p1_valid;
    end

    // Sweep FSM, address/remaining counters, read-latency tracker and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_remain   <= '0;
            r_base     <= '0;
            r_len      <= '0;
            r_p1_valid <= 1'b0;
            r_p1_last  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_p1_valid <= w_issue;
            r_p1_last  <= w_final_issue;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base   <= base;
                        r_len    <= len;
                        r_addr   <= base;
                        r_remain <= len;
                        if (len != '0) begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_final_issue && w_loop) begin
                        r_addr   <= r_base;
                        r_remain <= r_len;
                    end else if (w_issue) begin
                        r_addr   <= r_addr + AWIDTH'(1);
                        r_remain <= r_remain - (AWIDTH+1)'(1);
                        if (w_final_issue) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop_final) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    dpram_rd_skid_fifo #(
        .WIDTH (DWIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_p1_valid),
        .i_data  ({r_p1_last, rd_data}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign rd_addr = r_addr;
    assign m_valid = (w_count != 3'd0);
    assign m_data  = w_head[DWIDTH-1:0];
    assign m_last  = w_head[DWIDTH] && m_valid;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Directed scoreboard bench for dpram_stream_reader with a registered-read RAM model.
module tb_dpram_stream_reader;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   len;
`ifdef DPRAM_RD_LOOP_EN
    logic          loop;
`endif
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;

    dpram_stream_reader #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .base    (base),
        .len     (len),
`ifdef DPRAM_RD_LOOP_EN
        .loop    (loop),
`endif
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:31];
    always @(posedge clk) rd_data <= ram[rd_addr];

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   acc_cnt = 0;
    int   done_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    // Output monitor: scoreboard compare on each accepted word, hold check while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (prev_stall) begin
                tests++;
                assert ({m_valid, m_data, m_last} === {1'b1, prev_data, prev_last})
                else begin
                    fails++;
                    $error("FAIL stall_hold got v=%0b d=%h l=%0b exp v=1 d=%h l=%0b",
                           m_valid, m_data, m_last, prev_data, prev_last);
                end
            end
            if (m_valid && m_ready) begin
                tests++;
                assert (sb.size() > 0)
                else begin
                    fails++;
                    $error("FAIL sb_underflow got d=%h l=%0b exp no word", m_data, m_last);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    tests++;
                    assert ({m_data, m_last} === {e.d, e.l})
                    else begin
                        fails++;
                        $error("FAIL stream_word got d=%h l=%0b exp d=%h l=%0b",
                               m_data, m_last, e.d, e.l);
                    end
                    acc_cnt++;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive a one-cycle start and queue the words the sweep must produce.
    task automatic start_sweep(input int b, input int l);
        base  = AW'(b);
        len   = (AW+1)'(l);
        start = 1'b1;
        for (int i = 0; i < l; i++) begin
            sb.push_back({ram[(b + i) % 32], (i == l - 1)});
        end
        tick();
        start = 1'b0;
    endtask

    // Wait (bounded) until done is seen; returns in the done cycle.
    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, seen, 1);
    endtask

    initial begin
        int   a0;
        int   d0;
        logic seen;
        logic [3:0] pat;

        rst = 1'b1; start = 1'b0; base = '0; len = '0; m_ready = 1'b1;
`ifdef DPRAM_RD_LOOP_EN
        loop = 1'b0;
`endif
        for (int i = 0; i < 32; i++) ram[i] = 32'hC0DE_0000 + 32'(i);
        tick(); tick();
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data",  m_data, 0);
        chk("rst_m_last",  m_last, 0);
        chk("rst_busy",    busy, 0);
        chk("rst_done",    done, 0);
        rst = 1'b0;
        tick();

        // Basic sweep: exact cycle timing with m_ready held high.
        start_sweep(0, 8);
        chk("t1_rd_addr_c1", rd_addr, 0);
        for (int c = 1; c <= 12; c++) begin
            chk($sformatf("t1_valid_c%0d", c), m_valid, (c >= 3 && c <= 10));
            chk($sformatf("t1_last_c%0d", c),  m_last, (c == 10));
            chk($sformatf("t1_done_c%0d", c),  done, (c == 11));
            chk($sformatf("t1_busy_c%0d", c),  busy, (c <= 10));
            tick();
        end
        chk("t1_sb_empty", sb.size(), 0);

        // Address wrap past the top of the RAM, no gap in the stream.
        start_sweep(30, 4);
        for (int c = 1; c <= 6; c++) begin
            if (c <= 4) chk($sformatf("t2_addr_c%0d", c), rd_addr, (30 + c - 1) % 32);
            chk($sformatf("t2_valid_c%0d", c), m_valid, (c >= 3));
            tick();
        end
        wait_done("t2_done");
        chk("t2_sb_empty", sb.size(), 0);

        // Backpressure pattern 1,0,0,1 repeating.
        pat = 4'b1001;
        a0 = acc_cnt;
        m_ready = pat[0];
        start_sweep(8, 8);
        seen = 1'b0;
        for (int k = 1; k < 200; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            m_ready = pat[k % 4];
            tick();
        end
        chk("t3_done", seen, 1);
        chk("t3_count", acc_cnt - a0, 8);
        chk("t3_sb_empty", sb.size(), 0);
        m_ready = 1'b1;
        tick();

        // Zero-length start: done next cycle, nothing emitted.
        start_sweep(5, 0);
        chk("t4_len0_done", done, 1);
        chk("t4_len0_busy", busy, 0);
        chk("t4_len0_valid", m_valid, 0);
        tick();
        chk("t4_len0_done_off", done, 0);
        chk("t4_len0_valid2", m_valid, 0);

        // Start while busy is ignored.
        a0 = acc_cnt;
        start_sweep(2, 5);
        tick();
        base = AW'(20); len = (AW+1)'(3); start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t4_busy_done");
        chk("t4_busy_count", acc_cnt - a0, 5);
        chk("t4_busy_sb_empty", sb.size(), 0);
        tick();

        // Reset mid-sweep after three words, then a fresh short sweep.
        a0 = acc_cnt;
        start_sweep(0, 8);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (acc_cnt >= a0 + 3) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("t5_three_words", seen, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_rd_addr", rd_addr, 0);
        chk("t5_rst_m_valid", m_valid, 0);
        chk("t5_rst_m_data",  m_data, 0);
        chk("t5_rst_m_last",  m_last, 0);
        chk("t5_rst_busy",    busy, 0);
        chk("t5_rst_done",    done, 0);
        sb.delete();
        tick();
        rst = 1'b0;
        tick();
        a0 = acc_cnt;
        start_sweep(4, 2);
        wait_done("t5_done");
        chk("t5_count", acc_cnt - a0, 2);
        chk("t5_sb_empty", sb.size(), 0);
        tick();

`ifdef DPRAM_RD_LOOP_EN
        // Looping passes of three words; dropping loop ends after the current pass.
        a0 = acc_cnt;
        d0 = done_cnt;
        loop = 1'b1;
        base = AW'(0); len = (AW+1)'(3); start = 1'b1;
        for (int i = 0; i < 30; i++) sb.push_back({ram[i % 3], (i % 3 == 2)});
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (acc_cnt >= a0 + 7) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("t6_seven_words", seen, 1);
        chk("t6_no_done_while_loop", done_cnt - d0, 0);
        loop = 1'b0;
        wait_done("t6_done");
        tick();
        chk("t6_whole_passes", (acc_cnt - a0) % 3, 0);
        chk("t6_done_once", done_cnt - d0, 1);
        sb.delete();
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
